parking_slot_allocator: RTL and testbench
=========================================

// Module: parking_slot_allocator
// PURPOSE
//   Upstream of the ones counter. Tracks which of N_SLOTS parking spots are occupied,
//   serves car-entry requests by allocating the lowest-numbered free spot, and serves
//   car-exit requests by freeing a named spot. Presents the registered occupancy vector
//   new_capacity[N_SLOTS-1:0] for the downstream counter (bit i = 1 -> spot i occupied).
// PARAMETERS
//   N_SLOTS   8    number of parking spots (width of new_capacity)
//   IDX_W     3    spot index width, clog2(N_SLOTS)
//   TIMEOUT   16   max cycles in GRANT waiting for grant_ack before abandoning (>=1)
// PORTS
//   clk            in   1        single clock, rising edge
//   rst_n          in   1        synchronous reset, active-low
//   enter_valid    in   1        car at entry gate requests a spot
//   enter_ready    out  1        allocator can accept an entry request
//   exit_valid     in   1        car leaving spot exit_slot
//   exit_slot      in   IDX_W    spot being vacated
//   exit_ready     out  1        allocator can accept an exit request
//   grant_valid    out  1        a spot has been reserved for the entering car
//   grant_slot     out  IDX_W    reserved spot index, stable while grant_valid=1
//   grant_ack      in   1        car confirmed through gate; commits the reservation
//   grant_timeout  out  1        1-cycle pulse: reservation abandoned, no spot taken
//   err_exit       out  1        1-cycle pulse: exit requested for an already-free spot
//   new_capacity   out  N_SLOTS  registered occupancy vector
//   full           out  1        &new_capacity (combinational from register)
//   empty          out  1        ~|new_capacity (combinational from register)
// BEHAVIOUR
//   Clock/reset: one clock; reset is synchronous and active-low (rst_n sampled on clk).
//   Reset (any state, incl. mid-GRANT): state=IDLE, new_capacity=0, grant_valid=0,
//     grant_slot=0, grant_timeout=0, err_exit=0, timer=0; hence empty=1, full=0.
//   States: IDLE, GRANT.
//   IDLE:
//     - exit_ready=1. enter_ready = !full & !exit_valid (exit has priority).
//     - exit handshake (exit_valid): next edge clears new_capacity[exit_slot] if set;
//       if already 0, occupancy unchanged and err_exit=1 for exactly the next cycle.
//     - exit_slot >= N_SLOTS: treated as free spot -> err_exit, no change.
//     - enter handshake (enter_valid & enter_ready): next edge grant_slot <= lowest
//       index i with new_capacity[i]=0, timer<=0, state->GRANT. Occupancy NOT yet set.
//     - enter_valid while full: held off (enter_ready=0), no state change.
//   GRANT:
//     - grant_valid=1, grant_slot held; enter_ready=0, exit_ready=0.
//     - grant_ack=1: next edge sets new_capacity[grant_slot], state->IDLE, grant_valid=0.
//     - else timer increments; when timer==TIMEOUT-1 and no ack: next edge state->IDLE,
//       occupancy unchanged, grant_timeout=1 for one cycle.
//     - grant_ack on the timeout cycle wins (commit, no timeout pulse).
//   Latency: enter handshake -> grant_valid = 1 cycle; grant_ack -> new_capacity bit
//     set = 1 cycle; exit handshake -> bit cleared = 1 cycle.
//   Occupancy changes only by one bit per cycle; never set and cleared in same cycle.
//   grant_ack outside GRANT and exit_valid during GRANT are ignored.
// TESTING
//   T1 reset: drive rst_n=0 mid-GRANT with new_capacity=8'h0F -> next edge new_capacity=0,
//      grant_valid=0, empty=1, enter_ready=1.
//   T2 fill: 8 entries each acked 1 cycle after grant -> grant_slot 0..7 in order,
//      new_capacity=8'hFF, full=1, enter_ready=0 with enter_valid held high.
//   T3 reuse: from 8'hFF exit slot 3 -> new_capacity=8'hF7 next cycle; next entry ->
//      grant_slot=3, after ack 8'hFF.
//   T4 simultaneous: IDLE, new_capacity=8'h01, enter_valid=exit_valid=1, exit_slot=0 ->
//      enter_ready=0, next cycle 8'h00, then entry accepted, grant_slot=0.
//   T5 bad exit: new_capacity=8'h01, exit_slot=5 -> err_exit one-cycle pulse,
//      new_capacity stays 8'h01.
//   T6 timeout: TIMEOUT=16, entry granted, grant_ack held 0 -> grant_timeout pulses
//      16 cycles after grant_valid rises, grant_valid=0, new_capacity unchanged.

Source files
------------

// File: rtl/parking_slot_allocator.sv
// Parking slot allocator: tracks spot occupancy, reserves the lowest free spot for an
// entering car, commits it on grant_ack or abandons it after TIMEOUT cycles, and frees
// named spots on exit. new_capacity is the registered occupancy vector for downstream.
module parking_slot_allocator #(
  parameter int N_SLOTS = 8,
  parameter int IDX_W   = 3,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enter_valid,
  output logic               enter_ready,
  input  logic               exit_valid,
  input  logic [IDX_W-1:0]   exit_slot,
  output logic               exit_ready,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_slot,
  input  logic               grant_ack,
  output logic               grant_timeout,
  output logic               err_exit,
  output logic [N_SLOTS-1:0] new_capacity,
  output logic               full,
  output logic               empty
);

  // Timer only ever holds 0..TIMEOUT-1.
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [N_SLOTS-1:0] cap_q, cap_d;
  logic [IDX_W-1:0]   slot_q, slot_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               timeout_q, timeout_d;
  logic               err_q, err_d;

  logic               exit_in_range;
  logic               exit_hit;

  // Lowest-numbered free spot; scanning downward lets the last hit be the lowest index.
  function automatic logic [IDX_W-1:0] lowest_free(input logic [N_SLOTS-1:0] occ);
    lowest_free = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!occ[i]) lowest_free = IDX_W'(i);
    end
  endfunction

  assign exit_in_range = (32'(exit_slot) < 32'(N_SLOTS));
  assign exit_hit      = exit_in_range && cap_q[exit_slot];

  assign full          = &cap_q;
  assign empty         = ~|cap_q;
  assign new_capacity  = cap_q;
  assign grant_valid   = (state_q == GRANT);
  assign grant_slot    = slot_q;
  assign grant_timeout = timeout_q;
  assign err_exit      = err_q;
  // Exit requests win over entry requests when both arrive in IDLE.
  assign exit_ready    = (state_q == IDLE);
  assign enter_ready   = (state_q == IDLE) && !full && !exit_valid;

  // Next-state logic: exit/entry handling in IDLE, commit or abandon in GRANT.
  always_comb begin
    state_d   = state_q;
    cap_d     = cap_q;
    slot_d    = slot_q;
    timer_d   = timer_q;
    timeout_d = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (exit_valid) begin
          if (exit_hit) cap_d[exit_slot] = 1'b0;
          else          err_d            = 1'b1;
        end else if (enter_valid && !full) begin
          slot_d  = lowest_free(cap_q);
          timer_d = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (grant_ack) begin
          cap_d[slot_q] = 1'b1;
          state_d       = IDLE;
        end else if (timer_q == TMR_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and occupancy registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cap_q     <= '0;
      slot_q    <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cap_q     <= cap_d;
      slot_q    <= slot_d;
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_parking_slot_allocator.sv
// Bench for parking_slot_allocator: directed vector table, hand-written reset/timeout
// sequences, then randomized traffic compared against a spot-array reference model.
module tb_parking_slot_allocator;
  localparam int N  = 8;
  localparam int IW = 3;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, enter_valid, exit_valid, grant_ack;
  logic [IW-1:0] exit_slot;
  logic          enter_ready, exit_ready, grant_valid, grant_timeout, err_exit, full, empty;
  logic [IW-1:0] grant_slot;
  logic [N-1:0]  new_capacity;

  int n_chk  = 0;
  int n_fail = 0;

  parking_slot_allocator #(.N_SLOTS(N), .IDX_W(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .enter_valid(enter_valid), .enter_ready(enter_ready),
    .exit_valid(exit_valid), .exit_slot(exit_slot), .exit_ready(exit_ready),
    .grant_valid(grant_valid), .grant_slot(grant_slot), .grant_ack(grant_ack),
    .grant_timeout(grant_timeout), .err_exit(err_exit),
    .new_capacity(new_capacity), .full(full), .empty(empty)
  );

  typedef struct {
    logic       ev, xv;
    logic [2:0] xs;
    logic       ack;
    logic       e_rdy;
    logic [7:0] e_cap;
    logic       e_gv;
    logic [2:0] e_slot;
    logic       e_err, e_to;
  } vec_t;
  vec_t vq[$];

  function automatic void add(input logic ev, input logic xv, input logic [2:0] xs,
                              input logic ack, input logic e_rdy, input logic [7:0] e_cap,
                              input logic e_gv, input logic [2:0] e_slot,
                              input logic e_err, input logic e_to);
    vec_t v;
    v.ev = ev; v.xv = xv; v.xs = xs; v.ack = ack; v.e_rdy = e_rdy; v.e_cap = e_cap;
    v.e_gv = e_gv; v.e_slot = e_slot; v.e_err = e_err; v.e_to = e_to;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ev, input logic xv, input logic [IW-1:0] xs, input logic ack);
    enter_valid = ev; exit_valid = xv; exit_slot = xs; grant_ack = ack;
  endtask

  // Reference model state: one flag per spot plus reservation bookkeeping.
  bit m_occ[N];
  bit m_grant, m_to, m_err;
  int m_slot, m_wait;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_occ[i]);
    return c;
  endfunction

  function automatic logic [N-1:0] m_vec();
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = m_occ[i];
    return v;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < N; i++) m_occ[i] = 1'b0;
    m_grant = 0; m_to = 0; m_err = 0; m_slot = 0; m_wait = 0;
  endfunction

  function automatic void m_step(input bit rn, input bit ev, input bit xv, input int xs, input bit ack);
    bit to_n = 0, err_n = 0;
    if (!rn) begin
      m_reset();
      return;
    end
    if (m_grant) begin
      if (ack) begin
        m_occ[m_slot] = 1'b1;
        m_grant = 0;
      end else if (m_wait == TO - 1) begin
        m_grant = 0;
        to_n = 1;
      end else begin
        m_wait++;
      end
    end else if (xv) begin
      if (xs < N && m_occ[xs]) m_occ[xs] = 1'b0;
      else                     err_n = 1;
    end else if (ev && m_count() < N) begin
      for (int i = 0; i < N; i++) begin
        if (!m_occ[i]) begin
          m_slot = i;
          break;
        end
      end
      m_wait  = 0;
      m_grant = 1;
    end
    m_to  = to_n;
    m_err = err_n;
  endfunction

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0);

    // Directed table: fill, full hold-off, reuse, drain, bad exit, simultaneous, ignores.
    for (int s = 0; s < 8; s++) begin
      add(1, 0, 0, 0, 1, 8'((1 << s) - 1), 1, 3'(s), 0, 0);
      add(0, 0, 0, 1, 0, 8'((1 << (s + 1)) - 1), 0, 3'(s), 0, 0);
    end
    add(1, 0, 0, 0, 0, 8'hFF, 0, 0, 0, 0);
    add(0, 1, 3, 0, 0, 8'hF7, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 8'hF7, 1, 3, 0, 0);
    add(0, 0, 0, 1, 0, 8'hFF, 0, 3, 0, 0);
    for (int s = 7; s >= 1; s--) add(0, 1, 3'(s), 0, 0, 8'((1 << s) - 1), 0, 0, 0, 0);
    add(0, 1, 5, 0, 0, 8'h01, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 8'h01, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 8'h00, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 8'h01, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 8'h01, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 8'h01, 1, 1, 0, 0);
    add(0, 1, 0, 0, 0, 8'h01, 1, 1, 0, 0);
    add(0, 0, 0, 1, 0, 8'h03, 0, 1, 0, 0);

    // Reset state
    repeat (3) tick();
    chk("rst_cap", new_capacity, 0);
    chk("rst_gv", grant_valid, 0);
    chk("rst_slot", grant_slot, 0);
    chk("rst_to", grant_timeout, 0);
    chk("rst_err", err_exit, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_eready", enter_ready, 1);
    chk("rst_xready", exit_ready, 1);
    rst_n = 1'b1;
    tick();

    foreach (vq[k]) begin
      drive(vq[k].ev, vq[k].xv, vq[k].xs, vq[k].ack);
      #1;
      chk($sformatf("v%0d_enter_ready", k), enter_ready, vq[k].e_rdy);
      tick();
      chk($sformatf("v%0d_cap", k), new_capacity, vq[k].e_cap);
      chk($sformatf("v%0d_gv", k), grant_valid, vq[k].e_gv);
      if (vq[k].e_gv) chk($sformatf("v%0d_slot", k), grant_slot, vq[k].e_slot);
      chk($sformatf("v%0d_err", k), err_exit, vq[k].e_err);
      chk($sformatf("v%0d_to", k), grant_timeout, vq[k].e_to);
      chk($sformatf("v%0d_full", k), full, vq[k].e_cap == 8'hFF);
      chk($sformatf("v%0d_empty", k), empty, vq[k].e_cap == 8'h00);
    end
    drive(0, 0, 0, 0);
    tick();

    // Reset while a reservation is pending, with occupancy 8'h0F
    for (int s = 2; s < 4; s++) begin
      drive(1, 0, 0, 0); tick();
      drive(0, 0, 0, 1); tick();
    end
    drive(0, 0, 0, 0);
    chk("t1_pre_cap", new_capacity, 8'h0F);
    drive(1, 0, 0, 0); tick();
    drive(0, 0, 0, 0);
    chk("t1_gv", grant_valid, 1);
    chk("t1_slot", grant_slot, 4);
    rst_n = 1'b0;
    tick();
    chk("t1_cap", new_capacity, 0);
    chk("t1_gv_clr", grant_valid, 0);
    chk("t1_slot_clr", grant_slot, 0);
    chk("t1_empty", empty, 1);
    chk("t1_eready", enter_ready, 1);
    rst_n = 1'b1;
    tick();

    // Reservation abandoned after TIMEOUT cycles without ack
    drive(1, 0, 0, 0); tick();
    drive(0, 0, 0, 0);
    chk("t6_rise", grant_valid, 1);
    for (int c = 1; c < TO; c++) begin
      tick();
      chk($sformatf("t6_hold%0d", c), grant_valid, 1);
      chk($sformatf("t6_nopulse%0d", c), grant_timeout, 0);
    end
    tick();
    chk("t6_gv_drop", grant_valid, 0);
    chk("t6_pulse", grant_timeout, 1);
    chk("t6_cap", new_capacity, 0);
    tick();
    chk("t6_pulse_end", grant_timeout, 0);

    // Ack on the last permitted cycle commits instead of timing out
    drive(1, 0, 0, 0); tick();
    drive(0, 0, 0, 0);
    repeat (TO - 1) tick();
    chk("late_ack_gv", grant_valid, 1);
    drive(0, 0, 0, 1); tick();
    drive(0, 0, 0, 0);
    chk("late_ack_to", grant_timeout, 0);
    chk("late_ack_cap", new_capacity, 8'h01);
    chk("late_ack_gv_drop", grant_valid, 0);

    // Randomized traffic against the reference model
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    m_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int ack_pct;
      ack_pct = (cyc < 1000) ? 40 : 4;
      rst_n = ($urandom_range(0, 127) != 0);
      drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 25,
            IW'($urandom_range(0, N - 1)), $urandom_range(0, 99) < ack_pct);
      #1;
      chk("rnd_cap", new_capacity, m_vec());
      chk("rnd_gv", grant_valid, m_grant);
      if (m_grant) chk("rnd_slot", grant_slot, m_slot);
      chk("rnd_to", grant_timeout, m_to);
      chk("rnd_err", err_exit, m_err);
      chk("rnd_full", full, m_count() == N);
      chk("rnd_empty", empty, m_count() == 0);
      chk("rnd_xready", exit_ready, !m_grant);
      chk("rnd_eready", enter_ready, !m_grant && m_count() < N && !exit_valid);
      m_step(rst_n, enter_valid, exit_valid, int'(exit_slot), grant_ack);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
